// File: rtl/gecko_pkg.sv
// Shared types for the Gecko decode-side register scoreboard.
package gecko;

    localparam int GECKO_REG_STATUS_WIDTH = 2;

    // Per-register status: 0 means no write outstanding, all-ones means the
    // counter is saturated and no further issue to that register is possible.
    typedef logic [GECKO_REG_STATUS_WIDTH-1:0] gecko_reg_status_t;

    localparam gecko_reg_status_t GECKO_REG_STATUS_VALID = '0;
    localparam gecko_reg_status_t GECKO_REG_STATUS_FULL  = '1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } gecko_reg_scoreboard_state_t;

endpackage

// Decode-side helper types built on the scoreboard status encoding.
package gecko_decode_util;

    import gecko::*;

    // One status counter per architectural integer register (x0 included
    // so the array can be indexed directly by a 5-bit register address).
    typedef gecko_reg_status_t gecko_decode_reg_file_counter_t [32];

endpackage

// File: rtl/gecko_reg_scoreboard.sv
// Outstanding-write tracker for the Gecko integer register file. Each of
// x1..x31 has a small saturating-by-backpressure counter; a global total
// backs the drain FSM used for SYSTEM/FENCE ordering.
module gecko_reg_scoreboard
    import gecko::*;
#(
    parameter int STATUS_WIDTH = GECKO_REG_STATUS_WIDTH,
    parameter int TOTAL_WIDTH  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    output logic                    issue_ready,
    input  logic                    wb_valid,
    input  logic [4:0]              wb_rd,
    input  logic [4:0]              rs1_addr,
    input  logic [4:0]              rs2_addr,
    input  logic [4:0]              rd_addr,
    output logic [STATUS_WIDTH-1:0] rs1_status,
    output logic [STATUS_WIDTH-1:0] rs2_status,
    output logic [STATUS_WIDTH-1:0] rd_status,
    input  logic                    drain_req,
    output logic                    drain_done,
    output logic [TOTAL_WIDTH-1:0]  pending_count,
    output logic                    underflow_err
);

    localparam logic [STATUS_WIDTH-1:0] STATUS_FULL = '1;
    localparam logic [STATUS_WIDTH-1:0] STATUS_ONE  = STATUS_WIDTH'(1);
    localparam logic [TOTAL_WIDTH-1:0]  TOTAL_ONE   = TOTAL_WIDTH'(1);

    gecko_reg_scoreboard_state_t state_q, state_d;

    logic [STATUS_WIDTH-1:0] counters [32];
    logic [TOTAL_WIDTH-1:0]  total_q;

    logic issue_inc;
    logic wb_has_pending;
    logic wb_dec;
    logic wb_under;
    logic err_q;

    // x0 is never tracked, so its status is hard-wired to VALID.
    assign counters[0] = '0;

    assign issue_ready    = (state_q == RUN) &&
                            ((issue_rd == 5'd0) || (counters[issue_rd] != STATUS_FULL));
    assign issue_inc      = issue_valid && issue_ready && (issue_rd != 5'd0);
    assign wb_has_pending = (counters[wb_rd] != '0);
    assign wb_dec         = wb_valid && (wb_rd != 5'd0) && wb_has_pending;
    assign wb_under       = wb_valid && (wb_rd != 5'd0) && !wb_has_pending;

    assign rs1_status    = counters[rs1_addr];
    assign rs2_status    = counters[rs2_addr];
    assign rd_status     = counters[rd_addr];
    assign pending_count = total_q;
    assign underflow_err = err_q;
    assign drain_done    = (state_q == DRAIN) && (total_q == '0);

    for (genvar r = 1; r < 32; r++) begin : g_counter
        logic                    inc;
        logic                    dec;
        logic [STATUS_WIDTH-1:0] count_q;

        assign inc = issue_inc && (issue_rd == 5'(r));
        assign dec = wb_dec && (wb_rd == 5'(r));

        // Per-register count: issue adds one, a valid writeback removes one,
        // and both together on the same register cancel out.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                count_q <= '0;
            end else if (inc && !dec) begin
                count_q <= count_q + STATUS_ONE;
            end else if (!inc && dec) begin
                count_q <= count_q - STATUS_ONE;
            end
        end

        assign counters[r] = count_q;
    end

    // Global outstanding-write count, moved by the same events as the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
        end else if (issue_inc && !wb_dec) begin
            total_q <= total_q + TOTAL_ONE;
        end else if (!issue_inc && wb_dec) begin
            total_q <= total_q - TOTAL_ONE;
        end
    end

    // Sticky error flag for a writeback that had nothing to retire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (wb_under) begin
            err_q <= 1'b1;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter DRAIN on request; leave once the total has reached zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (total_q == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Scoreboard bench for gecko_reg_scoreboard: a driver pushes the expected
// per-cycle outputs from a simple register-count model; a monitor compares.
module tb_gecko_reg_scoreboard;

    localparam int SW  = 2;
    localparam int TW  = 7;
    localparam int MAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0;
    logic [4:0]    issue_rd = '0;
    logic          issue_ready;
    logic          wb_valid = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic [4:0]    rs1_addr = '0;
    logic [4:0]    rs2_addr = '0;
    logic [4:0]    rd_addr = '0;
    logic [SW-1:0] rs1_status;
    logic [SW-1:0] rs2_status;
    logic [SW-1:0] rd_status;
    logic          drain_req = 1'b0;
    logic          drain_done;
    logic [TW-1:0] pending_count;
    logic          underflow_err;

    gecko_reg_scoreboard #(.STATUS_WIDTH(SW), .TOTAL_WIDTH(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .rs1_status    (rs1_status),
        .rs2_status    (rs2_status),
        .rd_status     (rd_status),
        .drain_req     (drain_req),
        .drain_done    (drain_done),
        .pending_count (pending_count),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ready;
        int done;
        int pending;
        int err;
        int s1;
        int s2;
        int sd;
    } exp_t;

    exp_t exp_q[$];

    int  m_cnt [32];
    bit  m_drain;
    bit  m_err;
    int  checks   = 0;
    int  failures = 0;
    int  cycle_no = 0;

    function automatic int m_total();
        int s = 0;
        for (int i = 1; i < 32; i++) s += m_cnt[i];
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_drain = 1'b0;
        m_err   = 1'b0;
    endfunction

    task automatic check_output(input string name, input int cyc, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must be this cycle,
    // then advance the model by what the coming clock edge will commit.
    task automatic apply_stimulus(input bit iv, input int ird, input bit wv, input int wrd,
                                  input bit dr, input int a1, input int a2, input int ad);
        exp_t e;
        bit   accepted;
        bit   wb_ok;
        bit   wb_bad;
        @(posedge clk);
        #1;
        cycle_no++;
        issue_valid = iv;
        issue_rd    = 5'(ird);
        wb_valid    = wv;
        wb_rd       = 5'(wrd);
        drain_req   = dr;
        rs1_addr    = 5'(a1);
        rs2_addr    = 5'(a2);
        rd_addr     = 5'(ad);

        e.cyc     = cycle_no;
        e.ready   = (!m_drain && (ird == 0 || m_cnt[ird] < MAX)) ? 1 : 0;
        e.done    = (m_drain && m_total() == 0) ? 1 : 0;
        e.pending = m_total();
        e.err     = m_err ? 1 : 0;
        e.s1      = m_cnt[a1];
        e.s2      = m_cnt[a2];
        e.sd      = m_cnt[ad];
        exp_q.push_back(e);

        accepted = iv && (e.ready == 1);
        wb_ok    = wv && wrd != 0 && m_cnt[wrd] > 0;
        wb_bad   = wv && wrd != 0 && m_cnt[wrd] == 0;
        if (accepted && ird != 0) m_cnt[ird] = m_cnt[ird] + 1;
        if (wb_ok) m_cnt[wrd] = m_cnt[wrd] - 1;
        if (wb_bad) m_err = 1'b1;
        if (!m_drain) m_drain = dr;
        else if (e.done == 1) m_drain = 1'b0;
    endtask

    task automatic idle(input int a1, input int a2, input int ad);
        apply_stimulus(0, 0, 0, 0, 0, a1, a2, ad);
    endtask

    // Assert reset between edges, check the asynchronous effect, then release.
    task automatic do_reset(input string tag);
        #6;
        rst = 1'b0;
        #1;
        check_output({tag, "_pending"}, cycle_no, int'(pending_count), 0);
        check_output({tag, "_ready"}, cycle_no, int'(issue_ready), 1);
        check_output({tag, "_done"}, cycle_no, int'(drain_done), 0);
        check_output({tag, "_err"}, cycle_no, int'(underflow_err), 0);
        check_output({tag, "_rs1"}, cycle_no, int'(rs1_status), 0);
        check_output({tag, "_rs2"}, cycle_no, int'(rs2_status), 0);
        check_output({tag, "_rd"}, cycle_no, int'(rd_status), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every negative edge out of reset, compare against the oldest expectation.
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("issue_ready", e.cyc, int'(issue_ready), e.ready);
            check_output("drain_done", e.cyc, int'(drain_done), e.done);
            check_output("pending_count", e.cyc, int'(pending_count), e.pending);
            check_output("underflow_err", e.cyc, int'(underflow_err), e.err);
            check_output("rs1_status", e.cyc, int'(rs1_status), e.s1);
            check_output("rs2_status", e.cyc, int'(rs2_status), e.s2);
            check_output("rd_status", e.cyc, int'(rd_status), e.sd);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        rs1_addr = 5'd5;
        rs2_addr = 5'd7;
        rd_addr  = 5'd0;
        do_reset("por");

        $display("[TB] reset and x0 handling");
        idle(0, 5, 9);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);

        $display("[TB] fill x5 to FULL and retire one");
        apply_stimulus(1, 5, 0, 0, 0, 5, 6, 5);
        apply_stimulus(1, 5, 0, 0, 0, 5, 6, 5);
        apply_stimulus(1, 5, 0, 0, 0, 5, 6, 5);
        apply_stimulus(0, 5, 0, 0, 0, 5, 6, 5);
        apply_stimulus(1, 5, 0, 0, 0, 5, 6, 5);
        apply_stimulus(0, 6, 0, 0, 0, 5, 6, 5);
        apply_stimulus(0, 5, 1, 5, 0, 5, 6, 5);
        apply_stimulus(0, 5, 0, 0, 0, 5, 6, 5);

        $display("[TB] simultaneous issue and writeback");
        apply_stimulus(1, 7, 0, 0, 0, 7, 9, 7);
        apply_stimulus(1, 7, 1, 7, 0, 7, 9, 7);
        apply_stimulus(1, 9, 0, 0, 0, 7, 9, 7);
        apply_stimulus(1, 7, 1, 9, 0, 7, 9, 7);
        idle(7, 9, 7);

        $display("[TB] underflow is sticky");
        apply_stimulus(0, 0, 1, 10, 0, 10, 7, 5);
        idle(10, 7, 5);
        apply_stimulus(1, 11, 1, 11, 0, 11, 10, 7);
        apply_stimulus(0, 0, 1, 0, 0, 11, 10, 7);
        idle(11, 10, 7);
        do_reset("clr");

        $display("[TB] drain with pending writes");
        apply_stimulus(1, 3, 0, 0, 0, 3, 4, 3);
        apply_stimulus(1, 4, 0, 0, 0, 3, 4, 3);
        apply_stimulus(0, 3, 0, 0, 1, 3, 4, 3);
        apply_stimulus(1, 8, 1, 3, 1, 3, 4, 8);
        apply_stimulus(0, 0, 1, 4, 0, 3, 4, 8);
        idle(3, 4, 8);
        idle(3, 4, 8);
        apply_stimulus(0, 0, 0, 0, 1, 3, 4, 8);
        idle(3, 4, 8);
        idle(3, 4, 8);

        $display("[TB] reset in the middle of a drain");
        apply_stimulus(1, 3, 0, 0, 0, 3, 4, 3);
        apply_stimulus(1, 4, 0, 0, 0, 3, 4, 3);
        apply_stimulus(0, 0, 0, 0, 1, 3, 4, 3);
        idle(3, 4, 3);
        do_reset("middrain");
        idle(3, 4, 3);
        idle(3, 4, 3);
        idle(3, 4, 3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            apply_stimulus(($urandom_range(0, 3) != 0),
                           int'($urandom_range(0, 7)),
                           ($urandom_range(0, 2) == 0),
                           int'($urandom_range(0, 7)),
                           ($urandom_range(0, 24) == 0),
                           int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)));
        end
        idle(1, 2, 3);
        idle(4, 5, 6);

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            checks++;
            $display("[TB] FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gecko_reg_scoreboard.md
Name: gecko_reg_scoreboard

Overview:
- Per-register outstanding-write tracker for the Gecko integer register file.
- It produces the rd/rs1/rs2 `gecko_reg_status_t` values consumed by the decode stage's operand-readiness check.
- Decode issue increments a register's counter; writeback decrements it.
- A drain FSM lets decode stall until all outstanding writes retire, for SYSTEM/FENCE ordering.

Parameters:
- STATUS_WIDTH, 2, width of each per-register counter. MAX = 2^STATUS_WIDTH-1 is the FULL encoding.
- TOTAL_WIDTH, 7, width of the global outstanding counter. Must be >= 5+STATUS_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode wants to issue an instruction writing issue_rd
- issue_rd  in  5  destination register of the issuing instruction
- issue_ready  out  1  issue accepted this cycle when issue_valid && issue_ready
- wb_valid  in  1  writeback retires one write to wb_rd
- wb_rd  in  5  register being written back
- rs1_addr, rs2_addr, rd_addr  in  5 each  decode lookup addresses
- rs1_status, rs2_status, rd_status  out  STATUS_WIDTH each  counter value of the addressed register
- drain_req  in  1  request to wait for zero outstanding writes
- drain_done  out  1  drain complete; pulses one cycle
- pending_count  out  TOTAL_WIDTH  total outstanding writes
- underflow_err  out  1  sticky; writeback arrived for a register with count 0

Behaviour:
- State: counters[1..31], total counter, FSM state, error flag.
  - x0 is never tracked. Issue or writeback with rd=0 has no effect.
  - Status of x0 always reads VALID (0).
- Status encoding:
  - 0 = GECKO_REG_STATUS_VALID
  - MAX = GECKO_REG_STATUS_FULL
  - Intermediate values = pending count.
- Lookups are combinational reads of the registered counters; there is no same-cycle bypass. An accepted issue or writeback is visible on the status outputs the next cycle.
- issue_ready = (state==RUN) && (issue_rd==0 || counters[issue_rd]!=MAX).
  - issue_ready depends only on registered state, never on wb_valid or wb_rd.
  - issue_ready may be high while issue_valid is low.
- Accepted issue with rd!=0: counters[rd] +1 and total +1.
- wb_valid with wb_rd!=0:
  - If counters[wb_rd]>0: counters[wb_rd] -1 and total -1.
  - If counters[wb_rd]==0: counters unchanged; underflow_err set to 1 and held until reset.
- Simultaneous accepted issue and writeback:
  - Same register: that counter and total are unchanged net.
  - Different registers: both updates apply.
- Underflow writeback combined with a same-cycle issue to the same register: the counter increments (+1 only) and underflow_err is set.
- FSM states:
  - RUN: issue allowed. drain_req=1 moves to DRAIN next cycle.
  - DRAIN: issue_ready=0 and writebacks continue. drain_done = (state==DRAIN && total==0), combinational from registered state. On drain_done, return to RUN the next cycle.
- Minimum drain latency: drain_req in cycle N gives drain_done in cycle N+1 if nothing is pending.
- drain_req is ignored while in DRAIN.
- Reset (asserted at any time, including mid-drain), effective asynchronously:
  - all counters=0, total=0, state=RUN, underflow_err=0
  - hence issue_ready=1, drain_done=0, pending_count=0, all status outputs=0

Decomposition:
- In package `gecko`:
  - `gecko_reg_status_t` (STATUS_WIDTH-bit logic)
  - constants GECKO_REG_STATUS_VALID='0 and GECKO_REG_STATUS_FULL='1
  - FSM enum `gecko_reg_scoreboard_state_t` {RUN, DRAIN}
- In `gecko_decode_util`: the array typedef `gecko_decode_reg_file_counter_t`.
- No sub-module. One generate loop over registers 1..31 for counter update logic; total counter and FSM in the top body.

Test Plan:
- Reset then idle:
  - all status=0, issue_ready=1, pending_count=0, drain_done=0
  - lookups of x0 read 0 even after issue of rd=0 (pending_count stays 0)
- Issue rd=5 three times (W=2):
  - cycle after third issue: rd_status(5)=3 (FULL), issue_ready=0 for issue_rd=5, issue_ready=1 for issue_rd=6
  - one wb_rd=5: status 2, ready 1 next cycle
- Same cycle: issue rd=7 and wb rd=7 with counter=1 → counter stays 1, pending_count unchanged.
- Same cycle: issue rd=7 and wb rd=9 → counter7 +1, counter9 -1.
- wb_rd=10 with counter 0:
  - underflow_err=1 next cycle; pending_count unchanged
  - error persists through later traffic until rst low
- Drain:
  - issue rd=3, rd=4, then drain_req → DRAIN, issue_ready=0
  - wb 3 then wb 4 → drain_done high exactly the cycle pending_count reads 0; RUN and issue_ready=1 the next cycle
  - drain_req with nothing pending → drain_done one cycle later
- Reset asserted mid-DRAIN with pending_count=2: immediately pending_count=0, status=0, issue_ready=1, no drain_done after release.
